// File: rtl/gsim_mat_mem_responder.sv
// gsim_mat_mem_responder
// Responder side of the GSIM matrix-memory read interface. Read requests
// travel through a LATENCY-deep {valid, addr} pipeline. The word array is
// read when a request reaches the final stage, and that stage registers the
// returned word. A separate load port preloads the array.
// Optional feature: define MEM_STALL_EN to deassert o_mem_rrdy pseudo-randomly
// from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5). This exercises the
// requester's handshaking.
module gsim_mat_mem_responder #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 544,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    input  logic              i_ld_wen,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic [15:0]       o_rd_cnt,
    output logic              o_addr_err
);

    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              stall;
    logic              accept;
    logic              req_oor;
    logic              tap_vld;
    logic [ADDR_W-1:0] tap_addr;
    logic              tap_oor;

    logic [DATA_W-1:0] dout_reg;
    logic              dout_vld_reg;
    logic [15:0]       rd_cnt_reg;
    logic              addr_err_reg;

`ifdef MEM_STALL_EN
    logic [7:0] lfsr_reg;
    logic [7:0] lfsr_next;

    // The Fibonacci LFSR shifts left. The feedback taps are bits 7, 5, 4 and 3.
    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    // The LFSR advances every cycle. Its bit 0 decides whether this cycle stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // A load and an accept never share an edge, because rrdy drops while loading.
    assign o_mem_rrdy = !i_reset && !i_ld_wen && !stall;
    assign accept     = i_mem_rreq && o_mem_rrdy;
    assign req_oor    = ({1'b0, i_mem_addr} >= DEPTH_CMP);

    // Preload write port. Out-of-range load addresses are silently dropped.
    always_ff @(posedge i_clk) begin
        if (i_ld_wen && ({1'b0, i_ld_addr} < DEPTH_CMP)) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

    // The first LATENCY-1 slots hold {valid, addr}. The output register is the last slot.
    // Each slot's state (EMPTY/BUSY) is simply its valid bit.
    generate
        if (LATENCY > 1) begin : g_pipe
            logic              vld_reg  [LATENCY-1];
            logic [ADDR_W-1:0] addr_reg [LATENCY-1];

            for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    // The head slot captures the request on accept.
                    always_ff @(posedge i_clk or posedge i_reset) begin
                        if (i_reset) begin
                            vld_reg[gi] <= 1'b0;
                        end else begin
                            vld_reg[gi] <= accept;
                        end
                    end

                    // The head address follows the request bus. It only matters when vld is set.
                    always_ff @(posedge i_clk) begin
                        addr_reg[gi] <= i_mem_addr;
                    end
                end else begin : g_body
                    // Each middle slot shifts down from the previous slot.
                    always_ff @(posedge i_clk or posedge i_reset) begin
                        if (i_reset) begin
                            vld_reg[gi] <= 1'b0;
                        end else begin
                            vld_reg[gi] <= vld_reg[gi-1];
                        end
                    end

                    // The middle-slot address shifts alongside its valid bit.
                    always_ff @(posedge i_clk) begin
                        addr_reg[gi] <= addr_reg[gi-1];
                    end
                end
            end

            assign tap_vld  = vld_reg[LATENCY-2];
            assign tap_addr = addr_reg[LATENCY-2];
        end else begin : g_nopipe
            assign tap_vld  = accept;
            assign tap_addr = i_mem_addr;
        end
    endgenerate

    assign tap_oor = ({1'b0, tap_addr} >= DEPTH_CMP);

    // Final stage: read the array (returning the pre-load word on a same-edge write) and pulse vld.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
        end else begin
            dout_vld_reg <= tap_vld;
            if (tap_vld) begin
                dout_reg <= tap_oor ? '0 : mem[tap_addr];
            end
        end
    end

    // Count every accepted read, and latch any out-of-range accept until reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_cnt_reg   <= 16'd0;
            addr_err_reg <= 1'b0;
        end else if (accept) begin
            rd_cnt_reg <= rd_cnt_reg + 16'd1;
            if (req_oor) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

    assign o_mem_dout     = dout_reg;
    assign o_mem_dout_vld = dout_vld_reg;
    assign o_rd_cnt       = rd_cnt_reg;
    assign o_addr_err     = addr_err_reg;

endmodule

// File: tb/tb_gsim_mat_mem_responder.sv
// Testbench for gsim_mat_mem_responder.
// A table of single reads is checked against constant expectations. A
// reference model checks ready, response timing and data on every cycle
// through a queue of outstanding reads. Hand-written sequences cover
// back-to-back reads, load blocking, same-edge load/read, reset while reads
// are in flight, and (with MEM_STALL_EN) LFSR stalling.
module tb_gsim_mat_mem_responder;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 544;
    localparam int LATENCY = 2;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_mem_rreq = 1'b0;
    logic [ADDR_W-1:0] i_mem_addr = '0;
    logic              o_mem_rrdy;
    logic [DATA_W-1:0] o_mem_dout;
    logic              o_mem_dout_vld;
    logic              i_ld_wen = 1'b0;
    logic [ADDR_W-1:0] i_ld_addr = '0;
    logic [DATA_W-1:0] i_ld_data = '0;
    logic [15:0]       o_rd_cnt;
    logic              o_addr_err;

    gsim_mat_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mem_rreq(i_mem_rreq), .i_mem_addr(i_mem_addr), .o_mem_rrdy(o_mem_rrdy),
        .o_mem_dout(o_mem_dout), .o_mem_dout_vld(o_mem_dout_vld),
        .i_ld_wen(i_ld_wen), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .o_rd_cnt(o_rd_cnt), .o_addr_err(o_addr_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                due;
        int                addr;
        logic [DATA_W-1:0] data;
    } sb_t;

    typedef struct {
        int                addr;
        logic [DATA_W-1:0] dout;
        logic              err;
        logic [15:0]       cnt;
    } vec_t;

    sb_t               sb[$];
    int                vld_log[$];
    logic [DATA_W-1:0] mm [DEPTH];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                vld_total = 0;
    logic [15:0]       exp_cnt = 16'd0;
    logic              exp_err = 1'b0;
    logic [7:0]        lfsr_m = 8'hA5;

    function automatic logic stall_m();
`ifdef MEM_STALL_EN
        return lfsr_m[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: advance at each rising edge using the inputs applied before it.
    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
            if (i_reset) begin
                lfsr_m = 8'hA5;
            end else begin
                if (i_mem_rreq && !i_ld_wen && !stall_m()) begin
                    sb.push_back('{cyc + LATENCY - 1, int'(i_mem_addr), '0});
                    exp_cnt = exp_cnt + 16'd1;
                    if (int'(i_mem_addr) >= DEPTH) exp_err = 1'b1;
                end
                foreach (sb[i]) begin
                    if (sb[i].due == cyc) sb[i].data = (sb[i].addr < DEPTH) ? mm[sb[i].addr] : '0;
                end
                if (i_ld_wen && int'(i_ld_addr) < DEPTH) mm[i_ld_addr] = i_ld_data;
                lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            end
        end
    end

    // Monitor at the falling edge: check ready every cycle, and check each response against the queue.
    initial begin
        sb_t e;
        forever begin
            @(negedge i_clk);
            chk("rrdy", DATA_W'(o_mem_rrdy), DATA_W'(!i_reset && !i_ld_wen && !stall_m()));
            if (o_mem_dout_vld) begin
                vld_total++;
                vld_log.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("no_vld_expected", DATA_W'(o_mem_dout_vld), '0);
                end else begin
                    e = sb.pop_front();
                    $display("rsp cyc=%0d addr=%0d dout=%h", cyc, e.addr, o_mem_dout);
                    chk("vld_cycle", DATA_W'(cyc), DATA_W'(e.due));
                    chk("rd_data", o_mem_dout, e.data);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_vld", DATA_W'(o_mem_dout_vld), DATA_W'(1));
            end
        end
    end

    task automatic sync();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ld(input int a, input logic [DATA_W-1:0] d);
        i_ld_wen  = 1'b1;
        i_ld_addr = ADDR_W'(a);
        i_ld_data = d;
        sync();
        i_ld_wen  = 1'b0;
    endtask

    // Hold the request until it is accepted. Return just after the accept edge with rreq still high.
    task automatic do_read(input int a);
        bit got = 1'b0;
        i_mem_rreq = 1'b1;
        i_mem_addr = ADDR_W'(a);
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge i_clk);
            got = o_mem_rrdy;
            sync();
        end
        if (!got) chk("accept_timeout", DATA_W'(o_mem_rrdy), DATA_W'(1));
    endtask

    // Wait for the next vld pulse. Return at the falling edge where it is seen.
    task automatic wait_vld();
        bit seen = 1'b0;
        for (int n = 0; n < 32 && !seen; n++) begin
            @(negedge i_clk);
            seen = o_mem_dout_vld;
        end
        if (!seen) chk("vld_timeout", DATA_W'(o_mem_dout_vld), DATA_W'(1));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        sb.delete();
        exp_cnt = 16'd0;
        exp_err = 1'b0;
        lfsr_m  = 8'hA5;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        vec_t              vecs[7];
        logic [DATA_W-1:0] p543;
        logic [DATA_W-1:0] new3;
        int                idx0;
        int                vbefore;

        p543 = {8{32'hDEAD_0543}};
        new3 = {8{32'hC0FF_EE03}};
        vecs[0] = '{5,    {16{16'd5}},  1'b0, 16'd1};
        vecs[1] = '{0,    {16{16'd0}},  1'b0, 16'd2};
        vecs[2] = '{16,   {16{16'd16}}, 1'b0, 16'd3};
        vecs[3] = '{543,  p543,         1'b0, 16'd4};
        vecs[4] = '{544,  '0,           1'b1, 16'd5};
        vecs[5] = '{1023, '0,           1'b1, 16'd6};
        vecs[6] = '{7,    {16{16'd7}},  1'b1, 16'd7};

        // Reset state.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_dout", o_mem_dout, '0);
        chk("rst_vld", DATA_W'(o_mem_dout_vld), '0);
        chk("rst_cnt", DATA_W'(o_rd_cnt), '0);
        chk("rst_err", DATA_W'(o_addr_err), '0);
        chk("rst_rrdy", DATA_W'(o_mem_rrdy), '0);
        sync();
        i_reset = 1'b0;

        // Preload. Address 600 is out of range, so it is ignored and raises no error.
        for (int k = 0; k <= 16; k++) ld(k, {16{16'(k)}});
        ld(543, p543);
        ld(600, {8{32'h0BAD_0600}});

        // Table of single reads.
        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr);
            i_mem_rreq = 1'b0;
            wait_vld();
            $display("read addr=%0d dout=%h err=%0d cnt=%0d", vecs[i].addr, o_mem_dout, o_addr_err, o_rd_cnt);
            chk($sformatf("tbl%0d_dout", i), o_mem_dout, vecs[i].dout);
            chk($sformatf("tbl%0d_err", i), DATA_W'(o_addr_err), DATA_W'(vecs[i].err));
            chk($sformatf("tbl%0d_cnt", i), DATA_W'(o_rd_cnt), DATA_W'(vecs[i].cnt));
            sync();
        end

        // 17 back-to-back reads of addresses 0..16.
        idx0 = vld_log.size();
        for (int k = 0; k <= 16; k++) do_read(k);
        i_mem_rreq = 1'b0;
        for (int n = 0; n < 80 && vld_log.size() - idx0 < 17; n++) sync();
        chk("b2b_count", DATA_W'(vld_log.size() - idx0), DATA_W'(17));
        chk("b2b_cnt", DATA_W'(o_rd_cnt), DATA_W'(24));
`ifndef MEM_STALL_EN
        if (vld_log.size() - idx0 >= 17) chk("b2b_span", DATA_W'(vld_log[idx0 + 16] - vld_log[idx0]), DATA_W'(16));
`endif

        // Load held for 3 cycles with rreq high: nothing may be accepted.
        i_mem_rreq = 1'b1;
        i_mem_addr = ADDR_W'(4);
        i_ld_wen   = 1'b1;
        i_ld_addr  = ADDR_W'(20);
        i_ld_data  = {8{32'h1234_0020}};
        repeat (3) sync();
        i_ld_wen   = 1'b0;
        i_mem_rreq = 1'b0;
        @(negedge i_clk);
        chk("ld_block_cnt", DATA_W'(o_rd_cnt), DATA_W'(24));
        sync();

        // A load to addr 3 on the same edge as the final-stage read of addr 3 must return the old word.
        do_read(3);
        i_mem_rreq = 1'b0;
        repeat (LATENCY - 2) sync();
        ld(3, new3);
        wait_vld();
        chk("old_word", o_mem_dout, {16{16'd3}});
        sync();
        do_read(3);
        i_mem_rreq = 1'b0;
        wait_vld();
        chk("new_word", o_mem_dout, new3);
        chk("cnt_26", DATA_W'(o_rd_cnt), DATA_W'(26));
        sync();

        // Reset with two reads in flight: no response may appear.
        vbefore = vld_total;
        do_read(10);
        do_read(11);
        i_mem_rreq = 1'b0;
        do_reset();
        @(negedge i_clk);
        chk("post_rst_cnt", DATA_W'(o_rd_cnt), '0);
        chk("post_rst_err", DATA_W'(o_addr_err), '0);
        chk("post_rst_rrdy", DATA_W'(o_mem_rrdy), DATA_W'(!stall_m()));
        repeat (8) sync();
`ifndef MEM_STALL_EN
        chk("dropped_vld", DATA_W'(vld_total - vbefore), '0);
`endif

`ifdef MEM_STALL_EN
        // Stall: rreq held for 200 cycles. The monitor checks rrdy against the LFSR every cycle.
        vbefore = vld_total;
        i_mem_rreq = 1'b1;
        i_mem_addr = ADDR_W'(2);
        repeat (200) sync();
        i_mem_rreq = 1'b0;
        repeat (LATENCY + 3) sync();
        chk("stall_cnt", DATA_W'(o_rd_cnt), DATA_W'(exp_cnt));
        chk("stall_vld_vs_cnt", DATA_W'(vld_total - vbefore), DATA_W'(exp_cnt));
`endif

        repeat (10) sync();
        chk("sb_drained", DATA_W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
